// File: rtl/s_axis_rq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s_axis_rq_arbiter_pkg
// Brief    : Shared constants for the requester-request (RQ) stream path:
//            first-dword fmt bit that marks a TLP as carrying data, tuser
//            bit positions and the arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package s_axis_rq_arbiter_pkg;

  // fmt[1] of the first header dword: 1 = TLP carries data (posted write),
  // 0 = no-data request (non-posted read).
  localparam int NP_FMT_BIT            = 30;

  // tuser layout on the RQ stream
  localparam int TUSER_WIDTH           = 4;
  localparam int TUSER_ECRC_BIT        = 0;
  localparam int TUSER_POISON_BIT      = 1;
  localparam int TUSER_DISCONTINUE_BIT = 3;

  // Arbiter state encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage : s_axis_rq_arbiter_pkg
`default_nettype wire

// File: rtl/s_axis_rq_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : s_axis_rq_arbiter_rr_pick
// Brief    : Combinational round-robin picker. Scans the request vector
//            starting one past the previous winner and wrapping modulo
//            N_PORTS; returns the winner as one-hot and as an index.
// Revision : 1.0 - initial release
// ============================================================================
module s_axis_rq_arbiter_rr_pick #(
  parameter int N_PORTS = 2
) (
  input  logic [N_PORTS-1:0]         req,
  input  logic [$clog2(N_PORTS)-1:0] last_grant,
  output logic [N_PORTS-1:0]         grant_onehot,
  output logic [$clog2(N_PORTS)-1:0] grant_idx
);

  localparam int c_idx_w = $clog2(N_PORTS);

  logic [c_idx_w-1:0] w_cand;
  logic               w_found;

  // First requesting port after last_grant wins; nothing asserted if no request
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    w_cand       = '0;
    w_found      = 1'b0;
    for (int k = 1; k <= N_PORTS; k++) begin
      w_cand = c_idx_w'((int'(last_grant) + k) % N_PORTS);
      if (!w_found && req[w_cand]) begin
        w_found              = 1'b1;
        grant_idx            = w_cand;
        grant_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule : s_axis_rq_arbiter_rr_pick
`default_nettype wire

// File: rtl/s_axis_rq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : s_axis_rq_arbiter
// Brief    : Packet-level round-robin arbiter merging several requester
//            streams onto the single RQ stream. Whole TLPs are forwarded
//            without interleaving; outstanding non-posted requests are
//            limited by a credit counter released by the completion path.
// Revision : 1.0 - initial release
// ============================================================================
module s_axis_rq_arbiter
  import s_axis_rq_arbiter_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_NP     = 32
) (
  input  logic                              user_clk,
  input  logic                              user_reset,

  input  logic [N_PORTS*DATA_WIDTH-1:0]     s_axis_rq_tdata,
  input  logic [N_PORTS*KEEP_WIDTH-1:0]     s_axis_rq_tkeep,
  input  logic [N_PORTS-1:0]                s_axis_rq_tlast,
  input  logic [N_PORTS*TUSER_WIDTH-1:0]    s_axis_rq_tuser,
  input  logic [N_PORTS-1:0]                s_axis_rq_tvalid,
  output logic [N_PORTS-1:0]                s_axis_rq_tready,

  output logic [DATA_WIDTH-1:0]             m_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]             m_axis_rq_tkeep,
  output logic                              m_axis_rq_tlast,
  output logic [TUSER_WIDTH-1:0]            m_axis_rq_tuser,
  output logic                              m_axis_rq_tvalid,
  input  logic                              m_axis_rq_tready,

  input  logic                              np_release,
  output logic [$clog2(MAX_NP+1)-1:0]       np_outstanding,
  output logic [$clog2(N_PORTS)-1:0]        grant_id,
  output logic                              np_underflow
);

  localparam int                  c_idx_w     = $clog2(N_PORTS);
  localparam int                  c_cnt_w     = $clog2(MAX_NP + 1);
  localparam logic [c_cnt_w-1:0]  c_max_np    = c_cnt_w'(MAX_NP);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_idx_w-1:0]  c_last_port = c_idx_w'(N_PORTS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e         state_q, state_d;
  logic [c_idx_w-1:0] grant_id_q, grant_id_d;
  logic [c_idx_w-1:0] last_grant_q, last_grant_d;
  logic               first_q, first_d;
  logic [c_cnt_w-1:0] np_cnt_q, np_cnt_d;
  logic               np_underflow_q, np_underflow_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [N_PORTS-1:0] w_np_first;
  logic [N_PORTS-1:0] w_eligible;
  logic [N_PORTS-1:0] w_pick_onehot;
  logic [c_idx_w-1:0] w_pick_idx;
  logic               w_pick_valid;
  logic               w_credit_ok;
  logic               w_busy;
  logic               w_beat;
  logic               w_np_accept;

  assign w_credit_ok  = (np_cnt_q < c_max_np);
  assign w_busy       = (state_q == ST_BUSY);
  assign w_pick_valid = |w_pick_onehot;

  // Every port in IDLE sits at a packet boundary, so its head beat is a
  // first beat: reads need a free credit, writes are always eligible.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign w_np_first[gi] = ~s_axis_rq_tdata[gi*DATA_WIDTH + NP_FMT_BIT];
    assign w_eligible[gi] = s_axis_rq_tvalid[gi] & (~w_np_first[gi] | w_credit_ok);
  end

  s_axis_rq_arbiter_rr_pick #(
    .N_PORTS (N_PORTS)
  ) u_rr_pick (
    .req          (w_eligible),
    .last_grant   (last_grant_q),
    .grant_onehot (w_pick_onehot),
    .grant_idx    (w_pick_idx)
  );

  // Granted port drives the merged stream straight through while BUSY
  always_comb begin
    m_axis_rq_tdata  = s_axis_rq_tdata[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    m_axis_rq_tkeep  = s_axis_rq_tkeep[int'(grant_id_q)*KEEP_WIDTH +: KEEP_WIDTH];
    m_axis_rq_tuser  = s_axis_rq_tuser[int'(grant_id_q)*TUSER_WIDTH +: TUSER_WIDTH];
    m_axis_rq_tlast  = s_axis_rq_tlast[grant_id_q];
    m_axis_rq_tvalid = w_busy & s_axis_rq_tvalid[grant_id_q];
    s_axis_rq_tready = '0;
    if (w_busy) begin
      s_axis_rq_tready[grant_id_q] = m_axis_rq_tready;
    end
  end

  assign w_beat      = w_busy & s_axis_rq_tvalid[grant_id_q] & m_axis_rq_tready;
  assign w_np_accept = w_beat & first_q & w_np_first[grant_id_q];

  // Next-state logic: grant in IDLE, release the stream on the accepted tlast
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    first_d      = first_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_valid) begin
          state_d    = ST_BUSY;
          grant_id_d = w_pick_idx;
          first_d    = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_beat) begin
          first_d = 1'b0;
          if (m_axis_rq_tlast) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_id_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Credit counter: a simultaneous take and release cancel; a release with
  // nothing outstanding is dropped and flagged.
  always_comb begin
    np_cnt_d       = np_cnt_q;
    np_underflow_d = np_underflow_q;
    if (w_np_accept && !np_release) begin
      np_cnt_d = np_cnt_q + c_cnt_one;
    end else if (np_release && !w_np_accept) begin
      if (np_cnt_q == '0) begin
        np_underflow_d = 1'b1;
      end else begin
        np_cnt_d = np_cnt_q - c_cnt_one;
      end
    end
  end

  // All arbiter and credit state, asynchronously cleared
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q        <= ST_IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= c_last_port;
      first_q        <= 1'b0;
      np_cnt_q       <= '0;
      np_underflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      first_q        <= first_d;
      np_cnt_q       <= np_cnt_d;
      np_underflow_q <= np_underflow_d;
    end
  end

  assign grant_id       = grant_id_q;
  assign np_outstanding = np_cnt_q;
  assign np_underflow   = np_underflow_q;

endmodule : s_axis_rq_arbiter
`default_nettype wire

// File: tb/tb_s_axis_rq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_s_axis_rq_arbiter
// Brief    : Scoreboard bench for s_axis_rq_arbiter (2 ports, 64-bit data,
//            MAX_NP = 2). Per-port source queues feed the DUT; expected
//            merged beats are queued in hand-derived grant order and checked
//            by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s_axis_rq_arbiter;

  localparam int NP = 2;
  localparam int DW = 64;
  localparam int KW = 8;

  logic              clk;
  logic              user_reset;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP-1:0]     s_tlast;
  logic [NP*4-1:0]   s_tuser;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [3:0]        m_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic              np_release;
  logic [1:0]        np_outstanding;
  logic [0:0]        grant_id;
  logic              np_underflow;

  s_axis_rq_arbiter #(
    .N_PORTS    (NP),
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .MAX_NP     (2)
  ) dut (
    .user_clk         (clk),
    .user_reset       (user_reset),
    .s_axis_rq_tdata  (s_tdata),
    .s_axis_rq_tkeep  (s_tkeep),
    .s_axis_rq_tlast  (s_tlast),
    .s_axis_rq_tuser  (s_tuser),
    .s_axis_rq_tvalid (s_tvalid),
    .s_axis_rq_tready (s_tready),
    .m_axis_rq_tdata  (m_tdata),
    .m_axis_rq_tkeep  (m_tkeep),
    .m_axis_rq_tlast  (m_tlast),
    .m_axis_rq_tuser  (m_tuser),
    .m_axis_rq_tvalid (m_tvalid),
    .m_axis_rq_tready (m_tready),
    .np_release       (np_release),
    .np_outstanding   (np_outstanding),
    .grant_id         (grant_id),
    .np_underflow     (np_underflow)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [3:0]  user;
    logic        last;
    int          port;
  } beat_t;

  beat_t src0_q[$];
  beat_t src1_q[$];
  beat_t exp_q[$];
  int    hs_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic tog_mode = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Source driver: retire accepted head beats, present the next ones
  initial begin
    logic [1:0] fire;
    beat_t      b;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    s_tvalid = '0;
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      if (fire[0] && src0_q.size() > 0) void'(src0_q.pop_front());
      if (fire[1] && src1_q.size() > 0) void'(src1_q.pop_front());
      m_tready = tog_mode ? ~m_tready : 1'b1;
      if (src0_q.size() > 0) begin
        b = src0_q[0];
        s_tdata[63:0] = b.data;
        s_tkeep[7:0]  = b.keep;
        s_tuser[3:0]  = b.user;
        s_tlast[0]    = b.last;
        s_tvalid[0]   = 1'b1;
      end else begin
        s_tvalid[0] = 1'b0;
      end
      if (src1_q.size() > 0) begin
        b = src1_q[0];
        s_tdata[127:64] = b.data;
        s_tkeep[15:8]   = b.keep;
        s_tuser[7:4]    = b.user;
        s_tlast[1]      = b.last;
        s_tvalid[1]     = 1'b1;
      end else begin
        s_tvalid[1] = 1'b0;
      end
    end
  end

  // Monitor: ready routing on every presented beat, scoreboard on handshakes
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (m_tvalid) begin
        checks++;
        if ((s_tready & ~(2'b01 << grant_id)) != 2'b00) begin
          errors++;
          $display("FAIL other_ready actual=%b required=only port %0d", s_tready, grant_id);
        end
        checks++;
        if (s_tready[grant_id] !== m_tready) begin
          errors++;
          $display("FAIL grant_ready actual=%b required=%b", s_tready[grant_id], m_tready);
        end
      end
      if (m_tvalid && m_tready) begin
        hs_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=port%0d data=%h required=no beat", grant_id, m_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e.data || m_tkeep !== e.keep || m_tuser !== e.user ||
              m_tlast !== e.last || int'(grant_id) != e.port) begin
            errors++;
            $display("FAIL beat actual=port%0d data=%h keep=%h user=%h last=%b required=port%0d data=%h keep=%h user=%h last=%b",
                     grant_id, m_tdata, m_tkeep, m_tuser, m_tlast,
                     e.port, e.data, e.keep, e.user, e.last);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk(int port, logic [31:0] hi, logic [31:0] lo,
                               logic last, logic [3:0] user);
    beat_t b;
    b.data = {hi, lo};
    b.keep = lo[7:0] | 8'h0F;
    b.user = user;
    b.last = last;
    b.port = port;
    return b;
  endfunction

  // Single-beat write (fmt bit 30 set) and read (bit 30 clear)
  function automatic beat_t wr(int port, int seq);
    return mk(port, 32'hA000_0000 | 32'(port * 256 + seq), 32'h4000_0000 | 32'(seq), 1'b1, 4'(seq));
  endfunction

  function automatic beat_t rd(int port, int seq);
    return mk(port, 32'hB000_0000 | 32'(port * 256 + seq), 32'h0000_0020 | 32'(seq), 1'b1, 4'b0001);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(beat_t b);
    if (b.port == 0) src0_q.push_back(b);
    else             src1_q.push_back(b);
  endtask

  task automatic wait_exp(string name, int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d pending required=0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Returns on the negedge where a beat from 'port' is accepted
  task automatic wait_hs(string name, int port, int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (m_tvalid && m_tready && int'(grant_id) == port) break;
      n++;
      if (n >= budget) break;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_wait actual=no beat required=beat from port %0d", name, port);
    end
  endtask

  task automatic do_reset(string name);
    #2 user_reset = 1'b1;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    np_release = 1'b0;
    tog_mode   = 1'b0;
    #1;
    check({name, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    check({name, "_s_tready"}, 64'(s_tready), 64'd0);
    check({name, "_grant_id"}, 64'(grant_id), 64'd0);
    check({name, "_np_out"},   64'(np_outstanding), 64'd0);
    check({name, "_underflow"}, 64'(np_underflow), 64'd0);
    repeat (2) @(posedge clk);
    #1 user_reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    beat_t b;
    user_reset = 1'b1;
    np_release = 1'b0;
    do_reset("init");

    // ---- Alternating single-beat writes, one idle cycle between packets
    hs_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      push(wr(0, i));
      push(wr(1, i));
      exp_q.push_back(wr(0, i));
      exp_q.push_back(wr(1, i));
    end
    wait_exp("alt", 60);
    check("alt_beats", 64'(hs_cyc.size()), 64'd6);
    for (int i = 1; i < 6 && i < hs_cyc.size(); i++)
      check("alt_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);

    // ---- 4-beat write on port 1 under toggling downstream ready
    do_reset("rst_burst");
    tog_mode = 1'b1;
    hs_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      b = mk(1, 32'hC100_0000 | 32'(i), 32'h4000_0100 | 32'(i), (i == 3),
             (i == 3) ? 4'b1001 : 4'b0000);
      push(b);
      exp_q.push_back(b);
    end
    wait_hs("burst_first", 1, 40);
    push(wr(0, 7));
    exp_q.push_back(wr(0, 7));
    wait_exp("burst", 80);
    check("burst_beats", 64'(hs_cyc.size()), 64'd5);
    for (int i = 1; i < 4 && i < hs_cyc.size(); i++)
      check("burst_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);
    tog_mode = 1'b0;

    // ---- Read credit limit: two reads pass, write interleaves, third stalls
    do_reset("rst_credit");
    push(rd(0, 0));
    push(rd(0, 1));
    push(rd(0, 2));
    push(wr(1, 3));
    exp_q.push_back(rd(0, 0));
    exp_q.push_back(wr(1, 3));
    exp_q.push_back(rd(0, 1));
    wait_exp("credit", 60);
    repeat (5) @(posedge clk);
    #1;
    check("credit_np_full", 64'(np_outstanding), 64'd2);
    check("credit_stall_valid", 64'(m_tvalid), 64'd0);
    check("credit_stall_ready", 64'(s_tready), 64'd0);
    exp_q.push_back(rd(0, 2));
    np_release = 1'b1;
    @(posedge clk);
    #1 np_release = 1'b0;
    wait_exp("credit_release", 20);
    check("credit_np_after", 64'(np_outstanding), 64'd2);
    check("credit_underflow", 64'(np_underflow), 64'd0);

    // ---- Release coinciding with a read's first-beat acceptance at count 1
    do_reset("rst_coinc");
    push(rd(0, 4));
    exp_q.push_back(rd(0, 4));
    wait_exp("coinc_a", 20);
    check("coinc_np_one", 64'(np_outstanding), 64'd1);
    push(rd(0, 5));
    exp_q.push_back(rd(0, 5));
    wait_hs("coinc", 0, 20);
    np_release = 1'b1;
    @(posedge clk);
    #1 np_release = 1'b0;
    @(posedge clk);
    #1;
    check("coinc_np_hold", 64'(np_outstanding), 64'd1);
    check("coinc_underflow", 64'(np_underflow), 64'd0);

    // ---- Release with nothing outstanding
    do_reset("rst_uflow");
    np_release = 1'b1;
    @(posedge clk);
    #1 np_release = 1'b0;
    check("uflow_np", 64'(np_outstanding), 64'd0);
    check("uflow_flag", 64'(np_underflow), 64'd1);
    push(wr(1, 9));
    exp_q.push_back(wr(1, 9));
    wait_exp("uflow_wr", 20);
    check("uflow_sticky", 64'(np_underflow), 64'd1);
    check("uflow_np_wr", 64'(np_outstanding), 64'd0);

    // ---- Reset in the middle of a 3-beat packet on port 1
    do_reset("rst_mid_pre");
    push(wr(0, 10));
    exp_q.push_back(wr(0, 10));
    for (int i = 0; i < 3; i++) begin
      b = mk(1, 32'hD100_0000 | 32'(i), 32'h4000_0200 | 32'(i), (i == 2), 4'b0000);
      push(b);
      if (i == 0) exp_q.push_back(b);
    end
    wait_hs("mid_first", 1, 30);
    check("mid_exp_empty", 64'(exp_q.size()), 64'd0);
    do_reset("rst_mid");
    push(wr(1, 11));
    push(wr(0, 12));
    exp_q.push_back(wr(0, 12));
    exp_q.push_back(wr(1, 11));
    wait_exp("post_reset", 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_s_axis_rq_arbiter
`default_nettype wire
